microcode_sequencer: RTL and testbench

Control-unit sequencer that drives the 256x16 microcode ROM (`instruction_decoder`) and issues the resulting control word to the datapath. It keeps the micro-step counter and forms the ROM address from the instruction-register opcode and the step. It absorbs the ROM's one-cycle read latency, ends instructions early on an all-zero word, handles HLT, and supports free-run and single-step.

---
 rtl/microcode_sequencer.sv | 127 ++++++++++++
 tb/tb_microcode_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: steps through the instruction_decoder ROM, absorbs its
// one-cycle read latency and issues control words to the datapath.
module microcode_sequencer #(
    parameter int MAX_STEPS   = 8,
    parameter int FETCH_STEPS = 2,
    parameter int HLT_BIT     = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  opcode,
    input  logic        run,
    input  logic        step_req,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic [15:0] ctrl,
    output logic        ctrl_valid,
    output logic [3:0]  step,
    output logic        halted
);
    localparam logic [3:0] LAST_STEP = 4'(MAX_STEPS - 1);
    localparam logic [3:0] FETCH_END = 4'(FETCH_STEPS);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_EXEC, S_HALT} state_t;

    state_t     state_q, state_d;
    logic [3:0] step_q, step_d;
    logic [3:0] opsel_q, opsel_d;
    logic [7:0] rom_addr_q, rom_addr_d;
    logic       halted_q, halted_d;

    logic word_hlt;
    logic early_end;
    logic load_addr;

    // Fetch steps always read the shared opcode-0 rows; the opcode is captured
    // once, when the first body step is addressed, and held until the next fetch.
    function automatic logic [3:0] pick_opsel(input logic [3:0] s,
                                              input logic [3:0] op,
                                              input logic [3:0] held);
        if (s < FETCH_END) begin
            return 4'h0;
        end
        if (s == FETCH_END) begin
            return op;
        end
        return held;
    endfunction

    always_comb begin
        word_hlt   = rom_data[HLT_BIT];
        early_end  = !word_hlt && (rom_data == 16'h0000) && (step_q >= FETCH_END);
        // Gated by rst_n so nothing reaches the datapath in a reset cycle.
        ctrl_valid = rst_n && (state_q == S_EXEC) && !early_end;
        ctrl       = ctrl_valid ? rom_data : 16'h0000;
    end

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        opsel_d    = opsel_q;
        rom_addr_d = rom_addr_q;
        load_addr  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run || step_req) begin
                    load_addr = 1'b1;
                end
            end
            S_ADDR: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (word_hlt) begin
                    state_d = S_HALT;
                end else begin
                    if (early_end || (step_q == LAST_STEP)) begin
                        step_d = 4'h0;
                    end else begin
                        step_d = step_q + 4'd1;
                    end
                    // Single-step requests only count in IDLE, so only run chains steps.
                    if (run) begin
                        load_addr = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load_addr) begin
            state_d    = S_ADDR;
            opsel_d    = pick_opsel(step_d, opcode, opsel_q);
            rom_addr_d = {opsel_d, step_d};
        end

        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            step_q     <= 4'h0;
            opsel_q    <= 4'h0;
            rom_addr_q <= 8'h00;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            opsel_q    <= opsel_d;
            rom_addr_q <= rom_addr_d;
            halted_q   <= halted_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign step     = step_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: directed vector table, hand-written
// single-step / mid-instruction reset sequences, then randomized traffic.
module tb_microcode_sequencer;
    localparam int MAX_STEPS   = 8;
    localparam int FETCH_STEPS = 2;
    localparam int HLT_BIT     = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        step_req = 1'b0;
    logic [3:0]  opcode = 4'h0;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] ctrl;
    logic        ctrl_valid;
    logic [3:0]  step;
    logic        halted;

    logic [15:0] rom [256];

    int n_tests = 0;
    int n_fail  = 0;

    microcode_sequencer #(
        .MAX_STEPS  (MAX_STEPS),
        .FETCH_STEPS(FETCH_STEPS),
        .HLT_BIT    (HLT_BIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .run       (run),
        .step_req  (step_req),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .ctrl      (ctrl),
        .ctrl_valid(ctrl_valid),
        .step      (step),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    // Synchronous ROM with one cycle of read latency.
    always @(posedge clk) rom_data <= rom[rom_addr];

    typedef struct {
        logic        r;
        logic        ru;
        logic        sr;
        logic [3:0]  op;
        bit          chk;
        logic [7:0]  a;
        logic [15:0] c;
        logic        v;
        logic [3:0]  s;
        logic        h;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic ru, input logic sr, input logic [3:0] op,
                       input bit chk, input logic [7:0] a, input logic [15:0] c,
                       input logic v, input logic [3:0] s, input logic h);
        vec_t e;
        e.r = r; e.ru = ru; e.sr = sr; e.op = op; e.chk = chk;
        e.a = a; e.c = c; e.v = v; e.s = s; e.h = h;
        tbl.push_back(e);
    endtask

    task automatic check(input string name, input logic [7:0] a, input logic [15:0] c,
                         input logic v, input logic [3:0] s, input logic h);
        n_tests++;
        if (rom_addr !== a || ctrl !== c || ctrl_valid !== v || step !== s || halted !== h) begin
            n_fail++;
            $display("FAIL %s: got addr=%02h ctrl=%04h valid=%0b step=%0d halted=%0b, required addr=%02h ctrl=%04h valid=%0b step=%0d halted=%0b",
                     name, rom_addr, ctrl, ctrl_valid, step, halted, a, c, v, s, h);
        end
    endtask

    task automatic check_cv(input string name, input logic [15:0] c, input logic v);
        n_tests++;
        if (ctrl !== c || ctrl_valid !== v) begin
            n_fail++;
            $display("FAIL %s: got ctrl=%04h valid=%0b, required ctrl=%04h valid=%0b",
                     name, ctrl, ctrl_valid, c, v);
        end
    endtask

    // One clock: inputs change just after the rising edge, outputs are
    // observed at the falling edge.
    task automatic cycle(input logic r, input logic ru, input logic sr, input logic [3:0] op);
        @(posedge clk);
        #1;
        rst_n = r; run = ru; step_req = sr; opcode = op;
        @(negedge clk);
    endtask

    // Reference model: tracks the micro-step being worked on and how far
    // through its two-cycle address/execute window it is (m_age 1 = address
    // cycle, 2 = result cycle, 0 = nothing in flight).
    int         m_step;
    int         m_op;
    int         m_age;
    logic [7:0] m_addr;
    bit         m_halt;
    bit         m_known;

    task automatic model_issue();
        int op;
        if (m_step == FETCH_STEPS) m_op = int'(opcode);
        op = (m_step < FETCH_STEPS) ? 0 : m_op;
        m_addr = 8'(op * 16 + m_step);
        m_age = 1;
    endtask

    task automatic model_check();
        logic [15:0] w;
        logic [15:0] ec;
        logic        ev;
        w  = rom[m_addr];
        ev = 1'b0;
        ec = 16'h0000;
        if (rst_n && !m_halt && m_age == 2 && (w[HLT_BIT] || w != 16'h0 || m_step < FETCH_STEPS)) begin
            ev = 1'b1;
            ec = w;
        end
        check("random", m_addr, ec, ev, 4'(m_step), m_halt);
    endtask

    task automatic model_edge();
        logic [15:0] w;
        w = rom[m_addr];
        if (!rst_n) begin
            m_known = 1; m_step = 0; m_op = 0; m_addr = 8'h00; m_halt = 0; m_age = 0;
        end else if (!m_halt) begin
            if (m_age == 1) begin
                m_age = 2;
            end else if (m_age == 2) begin
                if (w[HLT_BIT]) begin
                    m_halt = 1;
                    m_age = 0;
                end else begin
                    if (w == 16'h0 && m_step >= FETCH_STEPS) m_step = 0;
                    else m_step = (m_step + 1) % MAX_STEPS;
                    if (run) model_issue();
                    else m_age = 0;
                end
            end else if (run || step_req) begin
                model_issue();
            end
        end
    endtask

    initial begin
        logic [15:0] ss_words [3];
        int pulses;
        logic ru;

        for (int a = 0; a < 256; a++) begin
            int r;
            r = $urandom_range(0, 15);
            rom[a] = (r < 3) ? 16'h0000 : {r == 3, 15'($urandom_range(1, 32767))};
        end
        for (int s = 0; s < 8; s++) rom[8'h20 + s] = {1'b0, 15'($urandom_range(1, 32767))};
        rom[8'h00] = 16'h4004; rom[8'h01] = 16'h1408; rom[8'h02] = 16'h0000;
        rom[8'h12] = 16'h4800; rom[8'h13] = 16'h1200; rom[8'h14] = 16'h0000;
        rom[8'hE2] = 16'h0110; rom[8'hF2] = 16'h8000;

        // r ru sr op chk addr ctrl v step h
        add(0, 1, 0, 4'h1, 0, 8'h00, 16'h0000, 0, 0, 0);
        add(0, 1, 0, 4'h1, 1, 8'h00, 16'h0000, 0, 0, 0);
        add(1, 1, 0, 4'h1, 1, 8'h00, 16'h0000, 0, 0, 0);
        add(1, 1, 0, 4'h1, 1, 8'h00, 16'h0000, 0, 0, 0);
        add(1, 1, 0, 4'h1, 1, 8'h00, 16'h4004, 1, 0, 0);
        add(1, 1, 0, 4'h1, 1, 8'h01, 16'h0000, 0, 1, 0);
        add(1, 1, 0, 4'h1, 1, 8'h01, 16'h1408, 1, 1, 0);
        add(1, 1, 0, 4'h1, 1, 8'h12, 16'h0000, 0, 2, 0);
        add(1, 1, 0, 4'h1, 1, 8'h12, 16'h4800, 1, 2, 0);
        add(1, 1, 0, 4'h1, 1, 8'h13, 16'h0000, 0, 3, 0);
        add(1, 1, 0, 4'h1, 1, 8'h13, 16'h1200, 1, 3, 0);
        add(1, 1, 0, 4'h1, 1, 8'h14, 16'h0000, 0, 4, 0);
        add(1, 1, 0, 4'h0, 1, 8'h14, 16'h0000, 0, 4, 0);
        add(1, 1, 0, 4'h0, 1, 8'h00, 16'h0000, 0, 0, 0);
        add(1, 1, 0, 4'h0, 1, 8'h00, 16'h4004, 1, 0, 0);
        add(1, 1, 0, 4'h0, 1, 8'h01, 16'h0000, 0, 1, 0);
        add(1, 1, 0, 4'h0, 1, 8'h01, 16'h1408, 1, 1, 0);
        add(1, 1, 0, 4'h0, 1, 8'h02, 16'h0000, 0, 2, 0);
        add(1, 1, 0, 4'hF, 1, 8'h02, 16'h0000, 0, 2, 0);
        add(1, 1, 0, 4'hF, 1, 8'h00, 16'h0000, 0, 0, 0);
        add(1, 1, 0, 4'hF, 1, 8'h00, 16'h4004, 1, 0, 0);
        add(1, 1, 0, 4'hF, 1, 8'h01, 16'h0000, 0, 1, 0);
        add(1, 1, 0, 4'hF, 1, 8'h01, 16'h1408, 1, 1, 0);
        add(1, 1, 0, 4'hF, 1, 8'hF2, 16'h0000, 0, 2, 0);
        add(1, 1, 0, 4'hF, 1, 8'hF2, 16'h8000, 1, 2, 0);
        add(1, 0, 1, 4'hF, 1, 8'hF2, 16'h0000, 0, 2, 1);
        add(1, 1, 1, 4'hF, 1, 8'hF2, 16'h0000, 0, 2, 1);
        add(0, 1, 0, 4'hF, 1, 8'hF2, 16'h0000, 0, 2, 1);
        add(1, 0, 0, 4'hF, 1, 8'h00, 16'h0000, 0, 0, 0);
        add(1, 0, 0, 4'hE, 1, 8'h00, 16'h0000, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].r, tbl[i].ru, tbl[i].sr, tbl[i].op);
            if (tbl[i].chk) check($sformatf("vec%0d", i), tbl[i].a, tbl[i].c, tbl[i].v, tbl[i].s, tbl[i].h);
        end

        // Single-step with extra requests during ADDR and EXEC.
        ss_words[0] = 16'h4004; ss_words[1] = 16'h1408; ss_words[2] = 16'h0110;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            cycle(1, 0, (i % 5) < 3, 4'hE);
            if (ctrl_valid === 1'b1) pulses++;
            if (i % 5 == 2) check_cv($sformatf("sstep%0d", i), ss_words[i / 5], 1'b1);
            else check_cv($sformatf("sstep%0d", i), 16'h0000, 1'b0);
        end
        n_tests++;
        if (pulses != 3 || step !== 4'd3) begin
            n_fail++;
            $display("FAIL sstep_count: got pulses=%0d step=%0d, required pulses=3 step=3", pulses, step);
        end

        // Reset landing on the EXEC cycle of step 2.
        cycle(0, 1, 0, 4'hE);
        cycle(0, 1, 0, 4'hE);
        for (int i = 0; i < 6; i++) cycle(1, 1, 0, 4'hE);
        check("midrst_addr", 8'hE2, 16'h0000, 1'b0, 4'd2, 1'b0);
        cycle(0, 1, 0, 4'hE);
        check("midrst_exec", 8'hE2, 16'h0000, 1'b0, 4'd2, 1'b0);
        cycle(1, 1, 0, 4'hE);
        check("midrst_idle", 8'h00, 16'h0000, 1'b0, 4'd0, 1'b0);
        cycle(1, 1, 0, 4'hE);
        check("midrst_addr0", 8'h00, 16'h0000, 1'b0, 4'd0, 1'b0);
        cycle(1, 1, 0, 4'hE);
        check("midrst_restart", 8'h00, 16'h4004, 1'b1, 4'd0, 1'b0);

        // Randomized traffic against the reference model.
        m_known = 0;
        ru = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            logic r;
            r = (i < 2) ? 1'b0 : ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 7) == 0) ru = ~ru;
            cycle(r, ru, $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)));
            if (m_known) model_check();
            model_edge();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
